pueo_threshold_loader: RTL and testbench

Upstream feeder for the chain of dual_pueo_threshold_v2 stages. Holds per-beam main thresholds and subthreshold offsets in a host-writable staging store. On command, it serially shifts them into the DSP A1/B1 cascade (thresh/thresh_wr). It then issues a single thresh_update pulse, so every beam's active threshold changes in the same cycle.

---
 rtl/pueo_thresh_pkg.sv | 27 ++
 rtl/pueo_thresh_stage_ram.sv | 36 +++
 rtl/pueo_threshold_loader.sv | 198 +++++++++++++++++++
 tb/tb_pueo_threshold_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pueo_thresh_pkg.sv
// Shared definitions for the PUEO threshold loader.
//   THRESH_W        : width of one threshold word (two's complement)
//   LANE_LO/LANE_HI : bit positions of the low (B port) and high (A port) lanes
//   SEL_MAIN/SEL_SUB: staging address bit 0, main threshold vs subthreshold offset
//   thresh_t        : one signed threshold word
//   loader_state_t  : loader FSM states
package pueo_thresh_pkg;

  localparam int THRESH_W = 18;

  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  localparam logic SEL_MAIN = 1'b0;
  localparam logic SEL_SUB  = 1'b1;

  typedef logic signed [THRESH_W-1:0] thresh_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/pueo_thresh_stage_ram.sv
// One staging bank: single write port, registered read port.
// A read and a write to the same entry in the same cycle returns the old
// contents. Contents are not reset.
// Ports:
//   clk_i     : clock
//   wrEn_i    : write strobe
//   wrAddr_i  : write address
//   wrDat_i   : write data
//   rdEn_i    : read strobe (output register updates only when high)
//   rdAddr_i  : read address
//   rdDat_o   : read data, valid the cycle after rdEn_i
module pueo_thresh_stage_ram
  import pueo_thresh_pkg::*;
#(
  parameter int DEPTH = 48,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          wrEn_i,
  input  logic [AW-1:0] wrAddr_i,
  input  thresh_t       wrDat_i,
  input  logic          rdEn_i,
  input  logic [AW-1:0] rdAddr_i,
  output thresh_t       rdDat_o
);

  thresh_t mem [DEPTH];

  // Both accesses in one process on the same edge: the read picks up the
  // value stored before this edge's write (read-first behaviour).
  always_ff @(posedge clk_i) begin
    if (wrEn_i) mem[wrAddr_i] <= wrDat_i;
    if (rdEn_i) rdDat_o <= mem[rdAddr_i];
  end

endmodule

// File: rtl/pueo_threshold_loader.sv
// Threshold loader for a chain of dual threshold stages.
// Host writes per-beam main thresholds and subthreshold offsets into a
// staging store; a load shifts all 2*NDUAL words into the A1/B1 cascade
// and then issues a single commit pulse so every beam changes together.
// Ports:
//   clk_i           : trigger-domain clock
//   rst_n_i         : asynchronous active-low reset
//   stg_addr_i      : staging address = 2*beam + sel (sel 0 main, 1 sub)
//   stg_dat_i       : staging write data
//   stg_wr_i        : staging write strobe
//   load_i          : start-load pulse
//   busy_o          : load in progress (READ through UPDATE)
//   done_o          : one-cycle pulse after the commit pulse
//   thresh_o        : cascade data, [17:0] even beam, [35:18] odd beam
//   thresh_wr_o     : shift enables, [0] low lane, [1] high lane
//   thresh_update_o : commit pulse for both lanes
//   state_o         : current FSM state (debug visibility)
//
// Handshake: load_i is a request strobe sampled every cycle. In IDLE it
// starts a load at once; at any other time it sets a one-deep pending flag
// that restarts the sequence directly out of DONE.
module pueo_threshold_loader
  import pueo_thresh_pkg::*;
#(
  parameter int NBEAMS = 48,
  parameter int AW     = $clog2(2*NBEAMS)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] stg_addr_i,
  input  logic [17:0]   stg_dat_i,
  input  logic          stg_wr_i,
  input  logic          load_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [35:0]   thresh_o,
  output logic [1:0]    thresh_wr_o,
  output logic [1:0]    thresh_update_o,
  output logic [2:0]    state_o
);

  localparam int NDUAL  = NBEAMS / 2;
  localparam int NWORDS = 2 * NDUAL;
  localparam int CW     = $clog2(NWORDS + 2);
  localparam int BAW    = AW - 1;   // bank address: {pair index, sel}
  localparam int MW     = AW - 2;   // pair index width

  loader_state_t state, nextState;
  logic          pending;
  logic [CW-1:0] shiftIdx;
  logic          restart;

  // Read side
  logic [CW-1:0] issueIdx;
  logic [CW-1:0] issueHalf;
  logic [MW-1:0] rdPair;
  logic [BAW-1:0] rdAddr;
  logic          rdEn;
  thresh_t       evenDat, oddDat;

  // Write side
  logic          addrOk;
  logic [BAW-1:0] wrAddr;
  logic          wrEven, wrOdd;

  assign restart = pending | load_i;

  // ---------------------------------------------------------------------
  // Staging banks. Address bit 1 is the beam parity (bank select); the
  // remaining bits form {beam/2, sel} inside the bank.
  // ---------------------------------------------------------------------
  if (2*NBEAMS == (1 << AW)) begin : g_addr_full
    assign addrOk = 1'b1;
  end else begin : g_addr_part
    assign addrOk = ({1'b0, stg_addr_i} < (AW+1)'(2*NBEAMS));
  end

  assign wrAddr = {stg_addr_i[AW-1:2], stg_addr_i[0]};
  assign wrEven = stg_wr_i & addrOk & ~stg_addr_i[1];
  assign wrOdd  = stg_wr_i & addrOk &  stg_addr_i[1];

  pueo_thresh_stage_ram #(.DEPTH(NBEAMS), .AW(BAW)) u_even_bank (
    .clk_i    (clk_i),
    .wrEn_i   (wrEven),
    .wrAddr_i (wrAddr),
    .wrDat_i  (stg_dat_i),
    .rdEn_i   (rdEn),
    .rdAddr_i (rdAddr),
    .rdDat_o  (evenDat)
  );

  pueo_thresh_stage_ram #(.DEPTH(NBEAMS), .AW(BAW)) u_odd_bank (
    .clk_i    (clk_i),
    .wrEn_i   (wrOdd),
    .wrAddr_i (wrAddr),
    .wrDat_i  (stg_dat_i),
    .rdEn_i   (rdEn),
    .rdAddr_i (rdAddr),
    .rdDat_o  (oddDat)
  );

  // ---------------------------------------------------------------------
  // Read issue. Word i is fetched in the cycle before it is needed on
  // thresh_o's register input: i=0 in the launch cycle (IDLE or DONE),
  // i=1 in READ, i+2 during SHIFT word i.
  // Word i belongs to pair m = NDUAL-1-i/2; even i is the sub offset.
  // ---------------------------------------------------------------------
  always_comb begin
    issueIdx = '0;
    rdEn     = 1'b0;
    unique case (state)
      ST_IDLE:  rdEn = load_i;
      ST_DONE:  rdEn = restart;
      ST_READ: begin
        issueIdx = CW'(1);
        rdEn     = 1'b1;
      end
      ST_SHIFT: begin
        issueIdx = shiftIdx + CW'(2);
        rdEn     = (issueIdx < CW'(NWORDS));
      end
      default: ;
    endcase
  end

  assign issueHalf = issueIdx >> 1;
  assign rdPair    = MW'(NDUAL - 1) - issueHalf[MW-1:0];
  assign rdAddr    = {rdPair, (issueIdx[0] ? SEL_MAIN : SEL_SUB)};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      pending  <= 1'b0;
      shiftIdx <= '0;
      thresh_o <= '0;
    end else begin
      state <= nextState;

      // DONE consumes the request (flag or same-cycle strobe) by
      // relaunching; elsewhere outside IDLE a strobe is remembered.
      if (state == ST_DONE)
        pending <= 1'b0;
      else if (load_i && state != ST_IDLE)
        pending <= 1'b1;

      if (state == ST_SHIFT)
        shiftIdx <= shiftIdx + CW'(1);
      else
        shiftIdx <= '0;

      // Capture the word that will be presented next cycle; on the last
      // SHIFT cycle nothing new was fetched, so thresh_o keeps its value.
      if (state == ST_READ ||
          (state == ST_SHIFT && shiftIdx != CW'(NWORDS - 1)))
        thresh_o <= {oddDat, evenDat};
    end
  end

  always_comb begin
    nextState       = state;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    thresh_wr_o     = 2'b00;
    thresh_update_o = 2'b00;
    unique case (state)
      ST_IDLE: begin
        if (load_i) nextState = ST_READ;
      end
      ST_READ: begin
        busy_o    = 1'b1;
        nextState = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy_o               = 1'b1;
        thresh_wr_o[LANE_LO] = 1'b1;
        thresh_wr_o[LANE_HI] = 1'b1;
        if (shiftIdx == CW'(NWORDS - 1)) nextState = ST_UPDATE;
      end
      ST_UPDATE: begin
        busy_o                   = 1'b1;
        thresh_update_o[LANE_LO] = 1'b1;
        thresh_update_o[LANE_HI] = 1'b1;
        nextState                = ST_DONE;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        nextState = restart ? ST_READ : ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_pueo_threshold_loader.sv
// Bench for pueo_threshold_loader with a 4-beam chain.
// The reference model tracks load runs as cycle windows relative to the
// READ cycle and snapshots staging contents when each word is fetched.
module tb_pueo_threshold_loader;

  localparam int NBEAMS = 4;
  localparam int AW     = 3;
  localparam int NDUAL  = NBEAMS / 2;
  localparam int NW     = 2 * NDUAL;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // DUT signals
  logic [AW-1:0] stg_addr_i = '0;
  logic [17:0]   stg_dat_i  = '0;
  logic          stg_wr_i   = 1'b0;
  logic          load_i     = 1'b0;
  logic          busy_o, done_o;
  logic [35:0]   thresh_o;
  logic [1:0]    thresh_wr_o, thresh_update_o;
  logic [2:0]    state_o;

  pueo_threshold_loader #(.NBEAMS(NBEAMS), .AW(AW)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .stg_addr_i      (stg_addr_i),
    .stg_dat_i       (stg_dat_i),
    .stg_wr_i        (stg_wr_i),
    .load_i          (load_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .thresh_o        (thresh_o),
    .thresh_wr_o     (thresh_wr_o),
    .thresh_update_o (thresh_update_o),
    .state_o         (state_o)
  );

  // scoreboard counters
  int nVec = 0;
  int nErr = 0;

  // reference model state
  logic [17:0] stg [2*NBEAMS];     // staging, indexed by 2*beam+sel
  logic [35:0] words [NW];         // words of the current run
  logic [35:0] lastThr = '0;
  int          cyc = 0;
  int          curStart = -100;    // READ cycle of the current/last run
  bit          pending = 1'b0;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s cycle %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {35'd0, busy_o}, 36'd0);
    check({tag, "_done"}, {35'd0, done_o}, 36'd0);
    check({tag, "_wr"},   {34'd0, thresh_wr_o}, 36'd0);
    check({tag, "_upd"},  {34'd0, thresh_update_o}, 36'd0);
    check({tag, "_thr"},  thresh_o, 36'd0);
  endtask

  function automatic logic [35:0] model_word(input int i);
    int m, sel;
    m   = NDUAL - 1 - i / 2;
    sel = (i % 2 == 0) ? 1 : 0;
    return {stg[2*(2*m+1) + sel], stg[2*(2*m) + sel]};
  endfunction

  // One clock cycle: drive inputs, advance the model, check outputs.
  task automatic cycle(input logic ld, input logic wr, input logic [AW-1:0] a, input logic [17:0] d);
    logic        eBusy, eDone;
    logic [1:0]  eWr, eUpd;
    logic [35:0] eThr;
    int          doneCyc;
    @(posedge clk_i);
    #1;
    load_i = ld; stg_wr_i = wr; stg_addr_i = a; stg_dat_i = d;

    // expectations for this cycle from the run windows
    doneCyc = curStart + NW + 2;
    eBusy = (cyc >= curStart) && (cyc <= curStart + NW + 1);
    eDone = (cyc == doneCyc);
    eWr   = ((cyc >= curStart + 1) && (cyc <= curStart + NW)) ? 2'b11 : 2'b00;
    eUpd  = (cyc == curStart + NW + 1) ? 2'b11 : 2'b00;
    if (cyc >= curStart + 1 && cyc <= curStart + NW) begin
      eThr    = words[cyc - curStart - 1];
      lastThr = eThr;
    end else begin
      eThr = lastThr;
    end

    // run scheduling
    if (ld) begin
      if (cyc >= curStart && cyc <= doneCyc) pending = 1'b1;
      else curStart = cyc + 1;
    end
    if (cyc == doneCyc && pending) begin
      curStart = cyc + 1;
      pending  = 1'b0;
    end

    // word i is fetched in cycle READ-1+i, before this cycle's write
    if (cyc >= curStart - 1 && cyc <= curStart - 2 + NW)
      words[cyc - curStart + 1] = model_word(cyc - curStart + 1);

    if (wr) stg[a] = d;

    @(negedge clk_i);
    check("busy", {35'd0, busy_o}, {35'd0, eBusy});
    check("done", {35'd0, done_o}, {35'd0, eDone});
    check("wr",   {34'd0, thresh_wr_o}, {34'd0, eWr});
    check("upd",  {34'd0, thresh_update_o}, {34'd0, eUpd});
    check("thr",  thresh_o, eThr);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0);
  endtask

  task automatic model_reset();
    curStart = -100;
    pending  = 1'b0;
    lastThr  = '0;
  endtask

  initial begin
    // reset state
    rst_n_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_zero_outputs("reset");
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // staging: main = 100+b, sub = 10+b
    for (int b = 0; b < NBEAMS; b++) begin
      cycle(1'b0, 1'b1, AW'(2*b),     18'(100 + b));
      cycle(1'b0, 1'b1, AW'(2*b + 1), 18'(10 + b));
    end

    // single load
    cycle(1'b1, 1'b0, '0, '0);
    idle(10);

    // overlapping requests at cycles 0, 3 and 4 of a load
    cycle(1'b1, 1'b0, '0, '0);
    idle(2);
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);
    idle(16);

    // write beam 1 main in the cycle its read is issued, then reload
    cycle(1'b1, 1'b0, '0, '0);
    idle(2);
    cycle(1'b0, 1'b1, AW'(2), 18'h3FFFB);
    idle(6);
    cycle(1'b1, 1'b0, '0, '0);
    idle(10);

    // reset in cycle 4 of a load
    cycle(1'b1, 1'b0, '0, '0);
    idle(3);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    cyc++;
    idle(8);
    cycle(1'b1, 1'b0, '0, '0);
    idle(10);

    // randomized loads and staging writes
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
            AW'($urandom_range(0, 2*NBEAMS - 1)), 18'($urandom));
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
